// File: rtl/counter_seq_ctrl_if.sv
// Handshake, configuration and counter-datapath signals of the counter sequencing controller.
// The master is the upstream requester plus counter datapath; the slave is the controller.
interface counter_seq_ctrl_if #(
   parameter int CNT_W = 4,
   parameter int REP_W = 4
);
   logic             start;
   logic [CNT_W-1:0] cfg_load;
   logic [CNT_W-1:0] cfg_term;
   logic [REP_W-1:0] cfg_reps;
   logic             cfg_auto;
   logic             pause;
   logic             abort;
   logic [CNT_W-1:0] cnt_val;
   logic             cnt_ld;
   logic [CNT_W-1:0] cnt_ld_val;
   logic             cnt_en;
   logic             busy;
   logic             tick;
   logic             done;
   logic             aborted;
   logic [REP_W-1:0] pass_idx;

   modport master (
      output start, cfg_load, cfg_term, cfg_reps, cfg_auto, pause, abort, cnt_val,
      input  cnt_ld, cnt_ld_val, cnt_en, busy, tick, done, aborted, pass_idx
   );

   modport slave (
      input  start, cfg_load, cfg_term, cfg_reps, cfg_auto, pause, abort, cnt_val,
      output cnt_ld, cnt_ld_val, cnt_en, busy, tick, done, aborted, pass_idx
   );
endinterface

// File: rtl/counter_seq_ctrl.sv
// Sequencing controller for an external up-counter: load, count to a terminal value,
// repeat for a programmed number of passes (or forever), with pause/abort handling.
module counter_seq_ctrl #(
   parameter int CNT_W = 4,
   parameter int REP_W = 4
) (
   input logic               clk,
   input logic               rst,
   counter_seq_ctrl_if.slave bus
);
   typedef enum logic [2:0] {IDLE, LOAD, RUN, HOLD, FINISH} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] load_sh, term_sh;
   logic [REP_W-1:0] reps_sh, pass_idx;
   logic             auto_sh, aborted;
   logic             accept, pass_inc, set_abort, tick_c, en_c;
   logic             term_hit, more_passes;
   logic [REP_W:0]   reps_eff, pass_nxt;

   // A programmed pass count of zero runs a single pass.
   assign term_hit    = (bus.cnt_val == term_sh);
   assign reps_eff    = (reps_sh == '0) ? (REP_W+1)'(1) : {1'b0, reps_sh};
   assign pass_nxt    = {1'b0, pass_idx} + (REP_W+1)'(1);
   assign more_passes = auto_sh || (pass_nxt < reps_eff);

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      pass_inc  = 1'b0;
      set_abort = 1'b0;
      tick_c    = 1'b0;
      en_c      = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               accept    = 1'b1;
               state_nxt = LOAD;
            end
         end
         LOAD: state_nxt = RUN;
         RUN: begin
            if (bus.abort) begin
               set_abort = 1'b1;
               state_nxt = FINISH;
            end else if (bus.pause) begin
               state_nxt = HOLD;
            end else if (term_hit) begin
               tick_c = 1'b1;
               if (more_passes) begin
                  pass_inc  = 1'b1;
                  state_nxt = LOAD;
               end else begin
                  state_nxt = FINISH;
               end
            end else begin
               en_c = 1'b1;
            end
         end
         // Leaving HOLD goes back through RUN so a match reached before the pause still ticks.
         HOLD: begin
            if (bus.abort) begin
               set_abort = 1'b1;
               state_nxt = FINISH;
            end else if (!bus.pause) begin
               state_nxt = RUN;
            end
         end
         FINISH:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         load_sh  <= '0;
         term_sh  <= '0;
         reps_sh  <= '0;
         auto_sh  <= 1'b0;
         pass_idx <= '0;
         aborted  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            load_sh  <= bus.cfg_load;
            term_sh  <= bus.cfg_term;
            reps_sh  <= bus.cfg_reps;
            auto_sh  <= bus.cfg_auto;
            pass_idx <= '0;
            aborted  <= 1'b0;
         end
         if (pass_inc)  pass_idx <= pass_nxt[REP_W-1:0];
         if (set_abort) aborted  <= 1'b1;
      end
   end

   // Reset suppresses the match-driven pulses in the cycle it is applied.
   assign bus.cnt_ld     = (state == LOAD);
   assign bus.cnt_ld_val = load_sh;
   assign bus.cnt_en     = en_c && !rst;
   assign bus.tick       = tick_c && !rst;
   assign bus.busy       = (state == LOAD) || (state == RUN) || (state == HOLD);
   assign bus.done       = (state == FINISH);
   assign bus.aborted    = aborted;
   assign bus.pass_idx   = pass_idx;
endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Self-checking bench for counter_seq_ctrl with a behavioural counter datapath in the loop.
module tb_counter_seq_ctrl;
   localparam int CNT_W = 4;
   localparam int REP_W = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   counter_seq_ctrl_if #(.CNT_W(CNT_W), .REP_W(REP_W)) bus ();
   counter_seq_ctrl #(.CNT_W(CNT_W), .REP_W(REP_W)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   // Counter datapath that the controller drives.
   logic [CNT_W-1:0] cnt = '0;
   always @(posedge clk) begin
      if (bus.cnt_ld)      cnt <= bus.cnt_ld_val;
      else if (bus.cnt_en) cnt <= cnt + 1'b1;
   end
   assign bus.cnt_val = cnt;

   typedef struct {int cyc; int idx;} tick_exp_t;
   typedef struct {
      logic [3:0] load;
      logic [3:0] term;
      logic [3:0] reps;
      int         ticks;
      int         done_cyc;
   } vec_t;

   tick_exp_t sb[$];
   vec_t      vt[6];
   int        nerr = 0;
   int        nchk = 0;
   int        cyc  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Drives start in the current cycle (cycle 0) and returns in cycle 1.
   task automatic start_run(input logic [3:0] l, input logic [3:0] t, input logic [3:0] r,
                            input logic a);
      bus.cfg_load = l;
      bus.cfg_term = t;
      bus.cfg_reps = r;
      bus.cfg_auto = a;
      bus.start    = 1'b1;
      cyc          = 0;
      step();
      bus.start = 1'b0;
      #1;
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_busy"}, bus.busy, 0);
      chk({name, "_done"}, bus.done, 0);
      chk({name, "_tick"}, bus.tick, 0);
      chk({name, "_ld"}, bus.cnt_ld, 0);
      chk({name, "_en"}, bus.cnt_en, 0);
      chk({name, "_aborted"}, bus.aborted, 0);
      chk({name, "_pidx"}, bus.pass_idx, 0);
      chk({name, "_ldval"}, bus.cnt_ld_val, 0);
   endtask

   task automatic run_vec(input vec_t v);
      int        d;
      int        reps_eff;
      int        got_ticks;
      bit        seen;
      tick_exp_t e;
      d        = (int'(v.term) - int'(v.load)) & 15;
      reps_eff = (v.reps == 4'd0) ? 1 : int'(v.reps);
      sb.delete();
      for (int p = 0; p < reps_eff; p++) sb.push_back(tick_exp_t'{2 + d + p * (d + 2), p});
      start_run(v.load, v.term, v.reps, 1'b0);
      chk("ld_first", bus.cnt_ld, 1);
      chk("ld_val", bus.cnt_ld_val, v.load);
      chk("aborted_clr", bus.aborted, 0);
      seen      = 1'b0;
      got_ticks = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
         chk("ld_en_excl", bus.cnt_ld & bus.cnt_en, 0);
         chk("busy", bus.busy, (cyc < v.done_cyc));
         if (bus.tick) begin
            got_ticks++;
            if (sb.size() == 0) begin
               chk("tick_extra", bus.tick, 0);
            end else begin
               e = sb.pop_front();
               chk("tick_cyc", cyc, e.cyc);
               chk("pass_idx", bus.pass_idx, e.idx);
               chk("tick_val", bus.cnt_val, v.term);
            end
         end
         if (bus.done) begin
            chk("done_cyc", cyc, v.done_cyc);
            chk("aborted_n", bus.aborted, 0);
            seen = 1'b1;
         end else begin
            step();
         end
      end
      if (!seen) chk("done_timeout", bus.done, 1);
      chk("tick_count", got_ticks, v.ticks);
      chk("sb_empty", sb.size(), 0);
      step();
      chk("idle_busy", bus.busy, 0);
   endtask

   initial begin
      int  n;
      bit  seen;
      bus.start    = 1'b0;
      bus.cfg_load = '0;
      bus.cfg_term = '0;
      bus.cfg_reps = '0;
      bus.cfg_auto = 1'b0;
      bus.pause    = 1'b0;
      bus.abort    = 1'b0;

      step();
      step();
      chk_all_zero("rst");
      rst = 1'b0;
      step();

      // Abort while idle does nothing.
      bus.abort = 1'b1;
      step();
      bus.abort = 1'b0;
      #1;
      chk("idle_abort_flag", bus.aborted, 0);
      chk("idle_abort_busy", bus.busy, 0);

      vt[0] = vec_t'{4'd3,  4'd7, 4'd1, 1, 7};
      vt[1] = vec_t'{4'd14, 4'd1, 4'd1, 1, 6};
      vt[2] = vec_t'{4'd0,  4'd2, 4'd3, 3, 13};
      vt[3] = vec_t'{4'd0,  4'd2, 4'd0, 1, 5};
      vt[4] = vec_t'{4'd5,  4'd5, 4'd1, 1, 3};
      vt[5] = vec_t'{4'd9,  4'd8, 4'd2, 2, 35};
      for (int i = 0; i < 6; i++) run_vec(vt[i]);

      // Pause for 5 cycles at cnt_val=5; HOLD needs one extra cycle to return to RUN.
      start_run(4'd0, 4'd9, 4'd1, 1'b0);
      while (cyc < 7) step();
      chk("pause_at5", cnt, 5);
      bus.pause = 1'b1;
      #1;
      for (int k = 0; k < 5; k++) begin
         chk("pause_en", bus.cnt_en, 0);
         chk("pause_busy", bus.busy, 1);
         step();
      end
      bus.pause = 1'b0;
      #1;
      chk("pause_hold_en", bus.cnt_en, 0);
      chk("pause_held", cnt, 5);
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         if (bus.tick) begin
            chk("pause_tick_cyc", cyc, 17);
            chk("pause_tick_val", cnt, 9);
         end
         if (bus.done) begin
            chk("pause_done_cyc", cyc, 12 + 6);
            seen = 1'b1;
         end else begin
            step();
         end
      end
      if (!seen) chk("pause_timeout", bus.done, 1);
      step();

      // Abort colliding with the terminal match.
      start_run(4'd0, 4'd3, 4'd1, 1'b0);
      while (cyc < 5) step();
      chk("abort_at_term", cnt, 3);
      bus.abort = 1'b1;
      #1;
      chk("abort_no_tick", bus.tick, 0);
      chk("abort_no_en", bus.cnt_en, 0);
      step();
      bus.abort = 1'b0;
      #1;
      chk("abort_done", bus.done, 1);
      chk("abort_flag", bus.aborted, 1);
      step();
      chk("abort_idle_busy", bus.busy, 0);
      chk("abort_flag_hold", bus.aborted, 1);

      // New start clears aborted; a second start while busy is ignored.
      start_run(4'd3, 4'd7, 4'd1, 1'b0);
      chk("restart_clr", bus.aborted, 0);
      step();
      bus.cfg_load = 4'd9;
      bus.cfg_term = 4'd2;
      bus.cfg_reps = 4'd5;
      bus.start    = 1'b1;
      step();
      bus.start = 1'b0;
      #1;
      seen = 1'b0;
      n    = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         if (bus.tick) begin
            n++;
            chk("busy_start_tick", cyc, 6);
            chk("busy_start_val", cnt, 7);
         end
         if (bus.done) begin
            chk("busy_start_done", cyc, 7);
            chk("busy_start_ldval", bus.cnt_ld_val, 3);
            seen = 1'b1;
         end else begin
            step();
         end
      end
      if (!seen) chk("busy_start_timeout", bus.done, 1);
      chk("busy_start_nticks", n, 1);
      step();

      // Reset in the middle of a run.
      start_run(4'd0, 4'd9, 4'd1, 1'b0);
      while (cyc < 6) step();
      chk("rst_mid_at4", cnt, 4);
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      chk_all_zero("rst_mid");
      for (int i = 0; i < 15; i++) begin
         chk("rst_mid_no_done", bus.done, 0);
         chk("rst_mid_no_tick", bus.tick, 0);
         step();
      end
      run_vec(vt[0]);

      // Continuous mode: pass_idx wraps, then abort from a non-matching RUN cycle.
      start_run(4'd0, 4'd1, 4'd0, 1'b1);
      n = 0;
      for (int i = 0; i < 200 && n < 18; i++) begin
         if (bus.tick) begin
            chk("auto_tick_cyc", cyc, 3 + 3 * n);
            chk("auto_pidx", bus.pass_idx, n & 15);
            n++;
         end
         if (n < 18) step();
      end
      chk("auto_nticks", n, 18);
      step();
      step();
      bus.abort = 1'b1;
      #1;
      chk("auto_abort_tick", bus.tick, 0);
      step();
      bus.abort = 1'b0;
      #1;
      chk("auto_abort_done", bus.done, 1);
      chk("auto_abort_flag", bus.aborted, 1);
      chk("auto_abort_pidx", bus.pass_idx, 2);
      step();
      chk("auto_idle", bus.busy, 0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
